// File: rtl/qmca_peak_sequencer.sv
// qmca_peak_sequencer
//   Per-channel pulse-height sequencer. Arms on ENABLE, waits for a sample strictly above
//   THRESHOLD, tracks the pulse maximum, then emits one tagged event word to the readout
//   FIFO and ignores HOLDOFF valid samples before re-arming.
//
//   Event word: {1'b1, TS[16:0], PEAK[13:0]}, TS = free-running count of valid samples
//   taken at the triggering sample.
//
//   Optional build macro QMCA_PEAK_WIDTH_EN: each event becomes a header/width word pair;
//   the width word is {16'b0, WIDTH[15:0]} with WIDTH = samples above threshold. When the
//   macro is undefined no width logic exists.

module qmca_peak_sequencer #(
    parameter int unsigned EVENT_BITS = 32,
    parameter int unsigned LOST_BITS  = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [13:0]           ADC_DATA,
    input  logic                  ADC_VALID,
    input  logic                  ENABLE,
    input  logic [13:0]           THRESHOLD,
    input  logic [7:0]            WINDOW,
    input  logic [7:0]            HOLDOFF,
    input  logic                  COUNTER_CLR,
    input  logic                  FIFO_FULL,
    output logic                  FIFO_WRITE,
    output logic [31:0]           FIFO_DATA,
    output logic [EVENT_BITS-1:0] EVENT_COUNT,
    output logic [LOST_BITS-1:0]  LOST_COUNT,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        StIdle,
        StArmed,
        StTrack,
        StEmit,
`ifdef QMCA_PEAK_WIDTH_EN
        StHold,
        StEmitWid
`else
        StHold
`endif
    } state_e;

    state_e      state;
    logic [16:0] ts_cnt;
    logic [16:0] ts_lat;
    logic [13:0] peak;
    logic [7:0]  wcnt;
    logic [7:0]  hcnt;

`ifdef QMCA_PEAK_WIDTH_EN
    logic [15:0] width;
    logic [15:0] width_next;
`endif

    logic        above;
    logic [7:0]  wcnt_next;
    logic        win_hit;
    logic        hold_done;
    logic        lost_sat;
    logic [31:0] hdr_word;

    // Strict crossing; THRESHOLD is used live.
    assign above     = ADC_DATA > THRESHOLD;
    // Window counter saturates so WINDOW=0 pulses can run indefinitely.
    assign wcnt_next = (wcnt == 8'hFF) ? wcnt : wcnt + 8'd1;
    // >= rather than == so a WINDOW lowered mid-pulse below the count still ends the pulse.
    assign win_hit   = (WINDOW != 8'd0) && (wcnt_next >= WINDOW);
    assign hold_done = ({1'b0, hcnt} + 9'd1) >= {1'b0, HOLDOFF};
    assign lost_sat  = (LOST_COUNT == {LOST_BITS{1'b1}});
    assign hdr_word  = {1'b1, ts_lat, peak};

`ifdef QMCA_PEAK_WIDTH_EN
    assign width_next = (width == 16'hFFFF) ? width : width + 16'd1;
`endif

    // Free-running timestamp: counts every valid sample regardless of state.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ts_cnt <= 17'd0;
        end else if (ADC_VALID) begin
            ts_cnt <= ts_cnt + 17'd1;
        end
    end

    // Sequencer FSM with registered FIFO strobe/data, BUSY and event/lost counters.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state       <= StIdle;
            ts_lat      <= 17'd0;
            peak        <= 14'd0;
            wcnt        <= 8'd0;
            hcnt        <= 8'd0;
            FIFO_WRITE  <= 1'b0;
            FIFO_DATA   <= 32'd0;
            EVENT_COUNT <= '0;
            LOST_COUNT  <= '0;
            BUSY        <= 1'b0;
`ifdef QMCA_PEAK_WIDTH_EN
            width       <= 16'd0;
`endif
        end else begin
            FIFO_WRITE <= 1'b0;

            unique case (state)
                StIdle: begin
                    if (ENABLE) begin
                        state <= StArmed;
                    end
                end

                StArmed: begin
                    if (!ENABLE) begin
                        state <= StIdle;
                    end else if (ADC_VALID && above) begin
                        // Triggering sample is the first sample of the pulse.
                        peak   <= ADC_DATA;
                        ts_lat <= ts_cnt;
                        wcnt   <= 8'd1;
                        BUSY   <= 1'b1;
`ifdef QMCA_PEAK_WIDTH_EN
                        width  <= 16'd1;
`endif
                        state  <= (WINDOW == 8'd1) ? StEmit : StTrack;
                    end
                end

                StTrack: begin
                    // ENABLE is deliberately ignored here: a started pulse always completes.
                    if (ADC_VALID) begin
                        if (ADC_DATA > peak) begin
                            peak <= ADC_DATA;
                        end
                        if (!above) begin
                            state <= StEmit;
                        end else begin
                            wcnt <= wcnt_next;
`ifdef QMCA_PEAK_WIDTH_EN
                            width <= width_next;
`endif
                            if (win_hit) begin
                                state <= StEmit;
                            end
                        end
                    end
                end

                StEmit: begin
                    hcnt <= 8'd0;
                    if (FIFO_FULL) begin
                        // Whole event (both words when width is enabled) is dropped.
                        if (!lost_sat) begin
                            LOST_COUNT <= LOST_COUNT + LOST_BITS'(1);
                        end
                        state <= StHold;
                    end else begin
                        FIFO_WRITE  <= 1'b1;
                        FIFO_DATA   <= hdr_word;
                        EVENT_COUNT <= EVENT_COUNT + EVENT_BITS'(1);
`ifdef QMCA_PEAK_WIDTH_EN
                        state       <= StEmitWid;
`else
                        state       <= StHold;
`endif
                    end
                end

`ifdef QMCA_PEAK_WIDTH_EN
                StEmitWid: begin
                    // Once the header is out the width word must follow: stall on full.
                    if (!FIFO_FULL) begin
                        FIFO_WRITE <= 1'b1;
                        FIFO_DATA  <= {16'd0, width};
                        hcnt       <= 8'd0;
                        state      <= StHold;
                    end
                end
`endif

                StHold: begin
                    if ((HOLDOFF == 8'd0) || (ADC_VALID && hold_done)) begin
                        BUSY  <= 1'b0;
                        state <= ENABLE ? StArmed : StIdle;
                    end else if (ADC_VALID) begin
                        hcnt <= hcnt + 8'd1;
                    end
                end

                default: begin
                    BUSY  <= 1'b0;
                    state <= StIdle;
                end
            endcase

            // Last assignment wins: a clear beats a same-cycle increment.
            if (COUNTER_CLR) begin
                EVENT_COUNT <= '0;
                LOST_COUNT  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_qmca_peak_sequencer.sv
// Directed bench for qmca_peak_sequencer. LOST_BITS is reduced to 4 so saturation of the
// lost counter is reachable in a short run. Width-word scenario runs only when
// QMCA_PEAK_WIDTH_EN is defined.

module tb_qmca_peak_sequencer;

    localparam int unsigned EB = 32;
    localparam int unsigned LB = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [13:0]   ADC_DATA = 14'd0;
    logic          ADC_VALID = 1'b0;
    logic          ENABLE = 1'b0;
    logic [13:0]   THRESHOLD = 14'd100;
    logic [7:0]    WINDOW = 8'd0;
    logic [7:0]    HOLDOFF = 8'd0;
    logic          COUNTER_CLR = 1'b0;
    logic          FIFO_FULL = 1'b0;
    logic          FIFO_WRITE;
    logic [31:0]   FIFO_DATA;
    logic [EB-1:0] EVENT_COUNT;
    logic [LB-1:0] LOST_COUNT;
    logic          BUSY;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [31:0] wr_data[$];
    int          wr_cyc[$];

    qmca_peak_sequencer #(
        .EVENT_BITS(EB),
        .LOST_BITS (LB)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .ADC_DATA   (ADC_DATA),
        .ADC_VALID  (ADC_VALID),
        .ENABLE     (ENABLE),
        .THRESHOLD  (THRESHOLD),
        .WINDOW     (WINDOW),
        .HOLDOFF    (HOLDOFF),
        .COUNTER_CLR(COUNTER_CLR),
        .FIFO_FULL  (FIFO_FULL),
        .FIFO_WRITE (FIFO_WRITE),
        .FIFO_DATA  (FIFO_DATA),
        .EVENT_COUNT(EVENT_COUNT),
        .LOST_COUNT (LOST_COUNT),
        .BUSY       (BUSY)
    );

    always #5 CLK = ~CLK;

    // One clock; outputs observed 1 time unit after the edge, writes logged with cycle no.
    task automatic clk_step();
        @(posedge CLK);
        #1;
        cyc++;
        if (FIFO_WRITE === 1'b1) begin
            wr_data.push_back(FIFO_DATA);
            wr_cyc.push_back(cyc);
        end
    endtask

    task automatic send(input logic [13:0] d);
        ADC_DATA  = d;
        ADC_VALID = 1'b1;
        clk_step();
        ADC_VALID = 1'b0;
    endtask

    task automatic do_reset();
        ADC_VALID   = 1'b0;
        ADC_DATA    = 14'd0;
        ENABLE      = 1'b0;
        THRESHOLD   = 14'd100;
        WINDOW      = 8'd0;
        HOLDOFF     = 8'd0;
        COUNTER_CLR = 1'b0;
        FIFO_FULL   = 1'b0;
        RST         = 1'b1;
        @(posedge CLK);
        #1;
        RST = 1'b0;
        wr_data.delete();
        wr_cyc.delete();
        cyc = 0;
    endtask

    // From ARMED: trigger, terminate, EMIT, HOLD(HOLDOFF=0) -> ARMED again.
    task automatic short_pulse();
        send(14'd200);
        send(14'd50);
        clk_step();
        clk_step();
    endtask

    task automatic test_reset();
        RST = 1'b1;
        #3;
        checks++; if (FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL rst_write got %0h want 0", FIFO_WRITE); end
        checks++; if (FIFO_DATA !== 32'd0) begin errors++; $display("FAIL rst_data got %h want 0", FIFO_DATA); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h want 0", BUSY); end
        do_reset();
        ENABLE = 1'b0;
        for (int i = 0; i < 5; i++) send(14'h3FFF);
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL idle_writes got %0d want 0", wr_data.size()); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL idle_busy got %0h want 0", BUSY); end
        checks++; if (EVENT_COUNT !== 32'd0) begin errors++; $display("FAIL idle_events got %0d want 0", EVENT_COUNT); end
        checks++; if (LOST_COUNT !== 4'd0) begin errors++; $display("FAIL idle_lost got %0d want 0", LOST_COUNT); end
    endtask

    task automatic test_basic_event();
        do_reset();
        ENABLE = 1'b1;
        clk_step();                 // cyc1: IDLE -> ARMED
        send(14'd50);               // TS0, below threshold
        send(14'd150);              // TS1, trigger
        send(14'd300);              // TS2, peak
        send(14'd200);              // TS3
        send(14'd90);               // TS4, cyc6: terminating edge
        checks++; if (FIFO_WRITE !== 1'b0) begin errors++; $display("FAIL basic_early_write got %0h want 0", FIFO_WRITE); end
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL basic_busy_emit got %0h want 1", BUSY); end
        clk_step();                 // cyc7: write visible
        clk_step();                 // cyc8: HOLD -> ARMED
        // {1, TS=1, PEAK=300}
        checks++; if (wr_data.size() != 1) begin errors++; $display("FAIL basic_nwrites got %0d want 1", wr_data.size()); end
        else begin
            checks++; if (wr_data[0] !== 32'h8000_412C) begin errors++; $display("FAIL basic_word got %h want 8000412c", wr_data[0]); end
            checks++; if (wr_cyc[0] != 7) begin errors++; $display("FAIL basic_latency got cyc %0d want 7", wr_cyc[0]); end
        end
        checks++; if (FIFO_DATA !== 32'h8000_412C) begin errors++; $display("FAIL basic_data_hold got %h want 8000412c", FIFO_DATA); end
        checks++; if (EVENT_COUNT !== 32'd1) begin errors++; $display("FAIL basic_events got %0d want 1", EVENT_COUNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL basic_busy_rearm got %0h want 0", BUSY); end
    endtask

    task automatic test_window_holdoff();
        do_reset();
        ENABLE  = 1'b1;
        WINDOW  = 8'd3;
        HOLDOFF = 8'd4;
        clk_step();                 // cyc1: ARMED
        // Sample TSk lands at cyc k+2. Trigger TS0, window ends at TS2, EMIT ignores TS3,
        // HOLD ignores TS4..TS7, retrigger at TS8, window ends TS10, EMIT at TS11.
        for (int i = 0; i < 12; i++) send(14'd500);
        checks++; if (wr_data.size() != 2) begin errors++; $display("FAIL win_nwrites got %0d want 2", wr_data.size()); end
        else begin
            checks++; if (wr_data[0] !== 32'h8000_01F4) begin errors++; $display("FAIL win_word0 got %h want 800001f4", wr_data[0]); end
            checks++; if (wr_cyc[0] != 5) begin errors++; $display("FAIL win_cyc0 got %0d want 5", wr_cyc[0]); end
            checks++; if (wr_data[1] !== 32'h8002_01F4) begin errors++; $display("FAIL win_word1 got %h want 800201f4", wr_data[1]); end
            checks++; if (wr_cyc[1] != 13) begin errors++; $display("FAIL win_cyc1 got %0d want 13", wr_cyc[1]); end
        end
        checks++; if (EVENT_COUNT !== 32'd2) begin errors++; $display("FAIL win_events got %0d want 2", EVENT_COUNT); end
    endtask

    task automatic test_fifo_full();
        do_reset();
        ENABLE    = 1'b1;
        FIFO_FULL = 1'b1;
        clk_step();
        short_pulse();
        checks++; if (LOST_COUNT !== 4'd1) begin errors++; $display("FAIL full_lost1 got %0d want 1", LOST_COUNT); end
        checks++; if (EVENT_COUNT !== 32'd0) begin errors++; $display("FAIL full_events got %0d want 0", EVENT_COUNT); end
        for (int i = 0; i < 14; i++) short_pulse();
        checks++; if (LOST_COUNT !== 4'd15) begin errors++; $display("FAIL full_lost15 got %0d want 15", LOST_COUNT); end
        short_pulse();
        checks++; if (LOST_COUNT !== 4'd15) begin errors++; $display("FAIL full_lost_sat got %0d want 15", LOST_COUNT); end
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL full_writes got %0d want 0", wr_data.size()); end
        COUNTER_CLR = 1'b1;
        clk_step();
        COUNTER_CLR = 1'b0;
        checks++; if (LOST_COUNT !== 4'd0) begin errors++; $display("FAIL full_clr got %0d want 0", LOST_COUNT); end
        // Clear coincident with the EMIT-cycle increment.
        send(14'd200);
        send(14'd50);
        COUNTER_CLR = 1'b1;
        clk_step();
        COUNTER_CLR = 1'b0;
        clk_step();
        checks++; if (LOST_COUNT !== 4'd0) begin errors++; $display("FAIL full_clr_wins got %0d want 0", LOST_COUNT); end
        FIFO_FULL = 1'b0;
    endtask

    task automatic test_enable_drop_and_reset();
        do_reset();
        ENABLE  = 1'b1;
        HOLDOFF = 8'd2;
        clk_step();
        send(14'd120);              // TS0 trigger
        ENABLE = 1'b0;
        send(14'd400);
        send(14'd130);
        send(14'd100);              // equal to threshold: terminates
        clk_step();
        checks++; if (FIFO_WRITE !== 1'b1) begin errors++; $display("FAIL drop_write got %0h want 1", FIFO_WRITE); end
        checks++; if (FIFO_DATA !== 32'h8000_0190) begin errors++; $display("FAIL drop_word got %h want 80000190", FIFO_DATA); end
        send(14'd10);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL drop_hold_busy got %0h want 1", BUSY); end
        send(14'd10);
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL drop_idle_busy got %0h want 0", BUSY); end
        for (int i = 0; i < 3; i++) send(14'd500);
        checks++; if (wr_data.size() != 1) begin errors++; $display("FAIL drop_nwrites got %0d want 1", wr_data.size()); end
        // Reset in the middle of a pulse.
        wr_data.delete();
        ENABLE = 1'b1;
        clk_step();
        send(14'd500);
        send(14'd600);
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL rtrk_busy got %0h want 1", BUSY); end
        RST = 1'b1;
        #1;
        checks++; if (FIFO_DATA !== 32'd0) begin errors++; $display("FAIL rtrk_data got %h want 0", FIFO_DATA); end
        checks++; if (EVENT_COUNT !== 32'd0) begin errors++; $display("FAIL rtrk_events got %0d want 0", EVENT_COUNT); end
        checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL rtrk_busy0 got %0h want 0", BUSY); end
        @(posedge CLK);
        #1;
        RST = 1'b0;
        for (int i = 0; i < 4; i++) send(14'd50);
        checks++; if (wr_data.size() != 0) begin errors++; $display("FAIL rtrk_writes got %0d want 0", wr_data.size()); end
    endtask

`ifdef QMCA_PEAK_WIDTH_EN
    task automatic test_width();
        do_reset();
        ENABLE = 1'b1;
        clk_step();
        send(14'd200);              // TS0 trigger
        send(14'd300);
        send(14'd250);
        send(14'd210);
        send(14'd150);              // TS4, fifth sample above
        send(14'd20);               // TS5 terminates
        clk_step();                 // header
        clk_step();                 // width word
        clk_step();                 // HOLD -> ARMED
        send(14'd200);              // TS6 trigger
        send(14'd300);
        send(14'd20);               // TS8 terminates
        clk_step();                 // header
        FIFO_FULL = 1'b1;
        clk_step();
        clk_step();
        checks++; if (BUSY !== 1'b1) begin errors++; $display("FAIL wid_stall_busy got %0h want 1", BUSY); end
        FIFO_FULL = 1'b0;
        clk_step();                 // width word after release
        checks++; if (wr_data.size() != 4) begin errors++; $display("FAIL wid_nwrites got %0d want 4", wr_data.size()); end
        else begin
            checks++; if (wr_data[0] !== 32'h8000_012C) begin errors++; $display("FAIL wid_hdr0 got %h want 8000012c", wr_data[0]); end
            checks++; if (wr_data[1] !== 32'h0000_0005) begin errors++; $display("FAIL wid_w0 got %h want 00000005", wr_data[1]); end
            checks++; if (wr_cyc[1] != wr_cyc[0] + 1) begin errors++; $display("FAIL wid_pair_gap got %0d want 1", wr_cyc[1] - wr_cyc[0]); end
            checks++; if (wr_data[2] !== 32'h8001_812C) begin errors++; $display("FAIL wid_hdr1 got %h want 8001812c", wr_data[2]); end
            checks++; if (wr_data[3] !== 32'h0000_0002) begin errors++; $display("FAIL wid_w1 got %h want 00000002", wr_data[3]); end
            checks++; if (wr_cyc[3] != wr_cyc[2] + 3) begin errors++; $display("FAIL wid_stall_gap got %0d want 3", wr_cyc[3] - wr_cyc[2]); end
        end
        checks++; if (EVENT_COUNT !== 32'd2) begin errors++; $display("FAIL wid_events got %0d want 2", EVENT_COUNT); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_event();
        test_window_holdoff();
        test_fifo_full();
        test_enable_drop_and_reset();
`ifdef QMCA_PEAK_WIDTH_EN
        test_width();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
